// File: rtl/peripheral_burst_ram_wb.sv
// peripheral_burst_ram_wb
//   Wishbone B3 registered-feedback RAM slave. It serves classic cycles at one
//   beat per two clocks and incrementing or wrapping bursts at one beat per
//   clock. Accesses at or beyond MEM_SIZE_BYTES end with err. Separate
//   counters track consumed write beats and consumed read beats.
//
// Ports
//   wb_clk_i, wb_rst_i   : clock and asynchronous active-high reset
//   wb_adr_i             : byte address; bits [1:0] are ignored
//   wb_dat_i, wb_sel_i   : write data and byte enables
//   wb_we_i              : write enable
//   wb_cyc_i, wb_stb_i   : cycle and strobe
//   wb_cti_i, wb_bte_i   : cycle type and burst type
//   wb_dat_o             : registered read data
//   wb_ack_o, wb_err_o   : registered beat termination
//   wb_rty_o             : tied to 0
//   wr_count_o           : number of consumed write beats
//   rd_count_o           : number of consumed read beats
//
// States
//   IDLE   | no beat offered; the next request loads the address
//   ACTIVE | a beat is offered, so ack or err is high

module peripheral_burst_ram_wb #(
    parameter int DW             = 32,
    parameter int AW             = 32,
    parameter int MEM_SIZE_BYTES = 1024
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    output logic [31:0]   wr_count_o,
    output logic [31:0]   rd_count_o
);

    localparam int AB    = $clog2(MEM_SIZE_BYTES);
    localparam int WORDS = MEM_SIZE_BYTES / 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [DW-1:0] mem [WORDS];

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   wr_count_q, wr_count_d;
    logic [31:0]   rd_count_q, rd_count_d;

    logic          req;
    logic          mem_we;
    logic          offer_en;
    logic [AW-1:0] offer_adr;

    // The upper bits of the word index stay fixed. Wrap bursts increment only
    // the low 2, 3 or 4 bits. A linear burst carries past the end of the RAM,
    // and the range check then ends it with err.
    function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a,
                                               input logic [1:0]    bte);
        logic [AW-3:0] w;
        logic [AW-3:0] w_inc;
        w     = a[AW-1:2];
        w_inc = w + (AW-2)'(1);
        case (bte)
            2'b01:   w = {w[AW-3:2], w_inc[1:0]};
            2'b10:   w = {w[AW-3:3], w_inc[2:0]};
            2'b11:   w = {w[AW-3:4], w_inc[3:0]};
            default: w = w_inc;
        endcase
        return {w, a[1:0]};
    endfunction

    assign req = wb_cyc_i & wb_stb_i;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dat_d      = dat_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        mem_we     = 1'b0;
        offer_en   = 1'b0;
        offer_adr  = addr_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d    = wb_adr_i;
                    offer_en  = 1'b1;
                    offer_adr = wb_adr_i;
                    state_d   = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!req) begin
                    state_d = IDLE;
                end else begin
                    // This edge consumes the offered beat. A beat that ended
                    // with err writes nothing and is not counted.
                    if (ack_q) begin
                        if (wb_we_i) begin
                            mem_we     = 1'b1;
                            wr_count_d = wr_count_q + 32'd1;
                        end else begin
                            rd_count_d = rd_count_q + 32'd1;
                        end
                    end
                    if (err_q || wb_cti_i != 3'b010) begin
                        state_d = IDLE;
                    end else begin
                        addr_d    = next_adr(addr_q, wb_bte_i);
                        offer_en  = 1'b1;
                        offer_adr = next_adr(addr_q, wb_bte_i);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Read data is fetched for writes as well. Within a burst the fetched
        // word is never the one being written on the same edge.
        if (offer_en) begin
            if (offer_adr < AW'(MEM_SIZE_BYTES)) begin
                ack_d = 1'b1;
                dat_d = mem[offer_adr[AB-1:2]];
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            dat_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dat_q      <= dat_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    // Reset does not clear the RAM. While reset is high the FSM is in IDLE,
    // so no write can happen.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (wb_sel_i[k]) begin
                    mem[addr_q[AB-1:2]][8*k +: 8] <= wb_dat_i[8*k +: 8];
                end
            end
        end
    end

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_rty_o   = 1'b0;
    assign wr_count_o = wr_count_q;
    assign rd_count_o = rd_count_q;

endmodule
